if_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register, the instruction memory, and the IF/ID pipeline register.
- Consumes the stall signal from the hazard-detection unit and the jump/branch redirect resolved in ID.
- Feeds the instruction and PC+4 to the ID stage; loaded and started by the debug unit.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/instruction_memory.sv | 28 ++
 rtl/if_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: data width, special encodings,
// fetch FSM states and jump type codes shared with the hazard unit.
package mips_pkg;

  localparam int unsigned NB_DATA = 32;

  localparam logic [NB_DATA-1:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [NB_DATA-1:0] NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    JumpNone   = 2'd0,
    JumpBranch = 2'd1,
    JumpDirect = 2'd2,
    JumpReg    = 2'd3
  } jump_type_e;

endpackage

// File: rtl/instruction_memory.sv
// Instruction memory: synchronous write port for debug loading,
// asynchronous read port for the fetch path.
module instruction_memory #(
  parameter int unsigned NB_ADDR = 8,
  parameter int unsigned NB_DATA = 32
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [NB_ADDR-1:0] i_raddr,
  output logic [NB_DATA-1:0] o_rdata
);

  localparam int unsigned Depth = 1 << NB_ADDR;

  logic [NB_DATA-1:0] mem_q [Depth];

  // No reset: program contents survive a pipeline reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch FSM, instruction memory and
// the IF/ID pipeline register.
module if_stage #(
  parameter int unsigned          NB_DATA    = mips_pkg::NB_DATA,
  parameter int unsigned          NB_ADDR    = 8,
  parameter logic [NB_DATA-1:0]   HALT_INSTR = mips_pkg::HALT_INSTR
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_jump_addr,
  input  logic               i_imem_we,
  input  logic [NB_ADDR-1:0] i_imem_waddr,
  input  logic [NB_DATA-1:0] i_imem_wdata,
  output logic [NB_DATA-1:0] o_instr,
  output logic [NB_DATA-1:0] o_pc_plus4,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_halt,
  output logic [1:0]         o_state,
  output logic [15:0]        o_fetch_count
);

  import mips_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [NB_DATA-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic [NB_DATA-1:0] pc4_q, pc4_d;
  logic [15:0]        cnt_q, cnt_d;

  logic [NB_DATA-1:0] mem_rdata;
  logic [NB_DATA-1:0] fetched;
  logic [NB_DATA-1:0] pc_plus4;
  logic [NB_DATA-1:0] jump_target;
  logic [15:0]        cnt_inc;
  logic               pc_in_range;
  logic               mem_we;
  logic               adv;

  // Loads are only allowed while the fetch path is not consuming memory.
  assign mem_we = i_imem_we && ((state_q == StIdle) || (state_q == StHalted));

  instruction_memory #(
    .NB_ADDR (NB_ADDR),
    .NB_DATA (NB_DATA)
  ) u_imem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (i_imem_waddr),
    .i_wdata (i_imem_wdata),
    .i_raddr (pc_q[NB_ADDR+1:2]),
    .o_rdata (mem_rdata)
  );

  // Any PC above the memory window fetches a NOP instead of aliasing.
  assign pc_in_range = (pc_q >> (NB_ADDR + 2)) == '0;
  assign fetched     = pc_in_range ? mem_rdata : NB_DATA'(NOP_INSTR);
  assign pc_plus4    = pc_q + NB_DATA'(4);
  assign jump_target = i_jump_addr & ~NB_DATA'(3);
  assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign adv         = (state_q == StRun) && i_enable && !i_stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StHalted: begin
        if (i_start) begin
          state_d = StRun;
          pc_d    = '0;
          instr_d = '0;
          pc4_d   = '0;
          cnt_d   = '0;
        end else if ((state_q == StHalted) && i_enable && !i_stall) begin
          instr_d = '0;
          pc4_d   = '0;
        end
      end
      StRun: begin
        if (adv) begin
          if (i_jump) begin
            pc_d    = jump_target;
            instr_d = '0;
            pc4_d   = '0;
          end else if (fetched == HALT_INSTR) begin
            state_d = StHalted;
            instr_d = HALT_INSTR;
            pc4_d   = pc_plus4;
            cnt_d   = cnt_inc;
          end else begin
            pc_d    = pc_plus4;
            instr_d = fetched;
            pc4_d   = pc_plus4;
            cnt_d   = cnt_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_instr       = instr_q;
  assign o_pc_plus4    = pc4_q;
  assign o_pc          = pc_q;
  assign o_halt        = (state_q == StHalted);
  assign o_state       = state_q;
  assign o_fetch_count = cnt_q;

endmodule
